// File: rtl/cluster_periph_rr_arbiter.sv
// Round-robin arbiter sharing one peripheral slave port among NB_MASTERS requesters.
// Responses are routed back in order through a small FIFO of granted master indices.
module cluster_periph_rr_arbiter #(
   parameter int unsigned NB_MASTERS      = 4,
   parameter int unsigned PER_ID_WIDTH    = 5,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,

   input  logic [NB_MASTERS-1:0]                    req_i,
   input  logic [NB_MASTERS-1:0][31:0]              add_i,
   input  logic [NB_MASTERS-1:0]                    wen_i,
   input  logic [NB_MASTERS-1:0][31:0]              wdata_i,
   input  logic [NB_MASTERS-1:0][3:0]               be_i,
   input  logic [NB_MASTERS-1:0][PER_ID_WIDTH-1:0]  id_i,
   output logic [NB_MASTERS-1:0]                    gnt_o,
   output logic [NB_MASTERS-1:0]                    r_valid_o,
   output logic [31:0]                              r_rdata_o,
   output logic                                     r_opc_o,
   output logic [PER_ID_WIDTH-1:0]                  r_id_o,

   output logic                                     slv_req_o,
   output logic [31:0]                              slv_add_o,
   output logic                                     slv_wen_o,
   output logic [31:0]                              slv_wdata_o,
   output logic [3:0]                               slv_be_o,
   output logic [PER_ID_WIDTH-1:0]                  slv_id_o,
   input  logic                                     slv_gnt_i,
   input  logic                                     slv_r_valid_i,
   input  logic [31:0]                              slv_r_rdata_i,
   input  logic                                     slv_r_opc_i,
   input  logic [PER_ID_WIDTH-1:0]                  slv_r_id_i,

   output logic                                     err_o
);

   localparam int unsigned IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [IDX_W-1:0] rr_q;
   logic [IDX_W-1:0] winner;
   logic             any_req;

   logic [IDX_W-1:0] fifo_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] head_idx;

   logic fifo_full;
   logic fifo_empty;
   logic fifo_full_eff;
   logic push;
   logic pop;
   logic accept;
   logic err_q;

   // Rotating priority search starting at rr_q.
   always_comb begin
      logic        found;
      logic [31:0] cand;
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      for (int k = 0; k < int'(NB_MASTERS); k++) begin
         cand = (32'(rr_q) + 32'(k)) % 32'(NB_MASTERS);
         if (!found && req_i[cand[IDX_W-1:0]]) begin
            winner = cand[IDX_W-1:0];
            found  = 1'b1;
         end
      end
   end

   assign any_req       = |req_i;
   assign fifo_full     = (cnt_q == CNT_W'(MAX_OUTSTANDING));
   assign fifo_empty    = (cnt_q == '0);
   assign pop           = slv_r_valid_i & ~fifo_empty;
   // A response popping this cycle frees a slot for a request in the same cycle.
   assign fifo_full_eff = fifo_full & ~pop;
   assign slv_req_o     = any_req & ~fifo_full_eff;
   assign accept        = slv_req_o & slv_gnt_i;
   assign push          = accept;
   assign head_idx      = fifo_mem[rd_ptr_q];

   assign slv_add_o   = any_req ? add_i[winner]   : '0;
   assign slv_wen_o   = any_req ? wen_i[winner]   : 1'b0;
   assign slv_wdata_o = any_req ? wdata_i[winner] : '0;
   assign slv_be_o    = any_req ? be_i[winner]    : '0;
   assign slv_id_o    = any_req ? id_i[winner]    : '0;

   assign r_rdata_o = pop ? slv_r_rdata_i : '0;
   assign r_opc_o   = pop ? slv_r_opc_i   : 1'b0;
   assign r_id_o    = pop ? slv_r_id_i    : '0;
   assign err_o     = err_q;

   for (genvar gi = 0; gi < NB_MASTERS; gi++) begin : g_port
      assign gnt_o[gi]     = accept & (winner == IDX_W'(gi));
      assign r_valid_o[gi] = pop & (head_idx == IDX_W'(gi));
   end

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (MAX_OUTSTANDING == 1) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
      if (i == IDX_W'(NB_MASTERS - 1)) begin
         return '0;
      end
      return i + IDX_W'(1);
   endfunction

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= winner;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            rr_q <= idx_inc(winner);
         end
         if (push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
         // Orphan response: nothing outstanding to route it to.
         if (slv_r_valid_i && fifo_empty) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule
